hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage core. It generates per-stage stall and flush enables from three sources:
- load-use hazards between Decode and Execute;
- taken branches/jumps resolved in Execute;
- multi-cycle data-memory accesses in Memory.

It works alongside the forwarding unit, covering the hazards forwarding cannot: load-use, control hazards and memory wait states. It also tracks a memory-wait timeout and a stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive cycles in MEM_WAIT before entering HALT (≥2).
- CNT_W, 32: width of stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rs1_D  in  5  source register 1 of instruction in Decode.
- rs2_D  in  5  source register 2 of instruction in Decode.
- rd_E  in  5  destination register of instruction in Execute.
- memread_E  in  1  instruction in Execute is a load.
- pcsrc_E  in  1  taken branch/jump resolved in Execute.
- memreq_M  in  1  load/store active in Memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- stall_F, stall_D, stall_E, stall_M  out  1  hold the PC / pipeline register of that stage.
- flush_D, flush_E, flush_W  out  1  convert that stage's register into a bubble.
- mem_timeout_err  out  1  sticky; set on entry to HALT.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_F=1.

## Operation
States: RUN, MEM_WAIT, HALT.

Stall and flush outputs are combinational from state and inputs. State, wait counter, error flag and stall_cycles are registered.

**Definitions**
- lwstall = memread_E & rd_E≠0 & (rd_E==rs1_D | rd_E==rs2_D).
- memfreeze = (state==RUN & memreq_M & ~dmem_ready) | (state==MEM_WAIT & ~dmem_ready) | state==HALT.

**Priority 1 — memfreeze=1**
- stall_F=stall_D=stall_E=stall_M=1, flush_W=1, flush_D=flush_E=0.
- lwstall and pcsrc_E are ignored; they are held and re-evaluated after the freeze.

**Priority 2 — otherwise, pcsrc_E=1**
- flush_D=flush_E=1, all stalls 0.
- lwstall is suppressed, because the Decode instruction is squashed.

**Priority 3 — otherwise, lwstall=1**
- stall_F=stall_D=1, flush_E=1.

**Otherwise:** all outputs 0.

**Transitions**
- RUN→MEM_WAIT when memreq_M & ~dmem_ready; wait_cnt←1.
- MEM_WAIT→RUN when dmem_ready. That cycle has no freeze, and the pipeline advances.
- MEM_WAIT, ~dmem_ready: wait_cnt increments; at wait_cnt==MEM_TIMEOUT-1 → HALT and mem_timeout_err←1.
- HALT is absorbing until reset.
- wait_cnt width is $clog2(MEM_TIMEOUT)+1.

**stall_cycles:** +1 each cycle stall_F=1; saturates at all-ones, with no wrap.

## Timing
- **Reset (while reset=1):** state=RUN, wait_cnt=0, mem_timeout_err=0, stall_cycles=0. Outputs are forced to flush_D=flush_E=1, all other outputs 0.
- **Reset mid-MEM_WAIT or in HALT:** returns to RUN the next cycle.
- **Latency:** stall/flush respond in the same cycle as their inputs (zero latency).
- **Memory access completing in 1 cycle** (dmem_ready=1 on first memreq_M cycle): no stall, no state change.
- **Access completing in N cycles:** exactly N-1 freeze cycles.
- **Simultaneous pcsrc_E and memreq_M wait:** freeze wins. The flush occurs in the cycle dmem_ready=1.
- **Simultaneous lwstall and pcsrc_E:** only the flush is applied; stall_F=0 so the branch target is fetched.
- **rd_E=x0:** never produces lwstall.

## Structure
- Package hazard_pkg holds typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} hz_state_t.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated for stall_cycles.
- Priority logic and FSM live in hazard_controller.

## Test plan
- **Load-use:** memread_E=1, rd_E=5, rs2_D=5, other inputs idle → stall_F=stall_D=flush_E=1 for one cycle; stall_cycles 0→1.
- **x0 / branch priority:**
  - rd_E=0, rs1_D=0, memread_E=1 → no stall.
  - Add pcsrc_E=1 with rd_E=5 matching rs1_D → flush_D=flush_E=1, stall_F=0.
- **3-cycle memory wait:** memreq_M=1 with dmem_ready low for 2 cycles, then high → freeze (4 stalls + flush_W) for exactly 2 cycles; state RUN→MEM_WAIT→RUN; stall_cycles=2.
- **Timeout:** MEM_TIMEOUT=4, dmem_ready held 0 → HALT on the 4th wait cycle, mem_timeout_err=1, freeze persists 20 further cycles. Assert reset → RUN, err=0, counter 0.
- **Freeze vs branch:** pcsrc_E=1 during MEM_WAIT → no flush until the dmem_ready cycle, then flush_D=flush_E=1 in that cycle.
- **Saturation:** CNT_W=3, hold lwstall 10 cycles → stall_cycles stops at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the FSM state encoding and the load-use detection function.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

  // Register x0 is hardwired to zero, so it can never create a load-use dependency.
  function automatic logic load_use(
    input logic              memread,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs1,
    input logic [REG_AW-1:0] rs2
  );
    return memread & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count enabled cycles, holding at the maximum value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencing for the 5-stage core: load-use, taken branches and
// multi-cycle data-memory accesses, with a memory-wait timeout and stall counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rd_E,
  input  logic              memread_E,
  input  logic              pcsrc_E,
  input  logic              memreq_M,
  input  logic              dmem_ready,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              flush_D,
  output logic              flush_E,
  output logic              flush_W,
  output logic              mem_timeout_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

  hz_state_t       r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_err;
  logic            w_lwstall;
  logic            w_memfreeze;

  assign w_lwstall = load_use(memread_E, rd_E, rs1_D, rs2_D);

  // Freeze whenever memory has not delivered, or permanently once halted
  always_comb begin
    w_memfreeze = 1'b0;
    case (r_state)
      RUN:      w_memfreeze = memreq_M & ~dmem_ready;
      MEM_WAIT: w_memfreeze = ~dmem_ready;
      HALT:     w_memfreeze = 1'b1;
      default:  w_memfreeze = 1'b1;
    endcase
  end

  // Priority resolution: reset, memory freeze, taken branch, load-use
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (reset) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (w_memfreeze) begin
      // Branch and load-use are held in place and re-evaluated after the freeze
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (pcsrc_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (w_lwstall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      stall_F = 1'b0;
    end
  end

  // Memory-wait FSM with timeout into an absorbing HALT state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (memreq_M && !dmem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end else begin
            r_state    <= RUN;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
            r_state    <= HALT;
            r_err      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_timeout_err = r_err;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_F),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT=4, CNT_W=3).
module tb_hazard_controller;
  import hazard_pkg::*;

  localparam int CNT_W = 3;

  // Expected output vectors: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  localparam logic [6:0] O_NONE   = 7'b0000_000;
  localparam logic [6:0] O_FREEZE = 7'b1111_001;
  localparam logic [6:0] O_BRANCH = 7'b0000_110;
  localparam logic [6:0] O_LW     = 7'b1100_010;
  localparam logic [6:0] O_RST    = 7'b0000_110;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs1_D, rs2_D, rd_E;
  logic             memread_E, pcsrc_E, memreq_M, dmem_ready;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  hazard_controller #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rs1_D           (rs1_D),
    .rs2_D           (rs2_D),
    .rd_E            (rd_E),
    .memread_E       (memread_E),
    .pcsrc_E         (pcsrc_E),
    .memreq_M        (memreq_M),
    .dmem_ready      (dmem_ready),
    .stall_F         (stall_F),
    .stall_D         (stall_D),
    .stall_E         (stall_E),
    .stall_M         (stall_M),
    .flush_D         (flush_D),
    .flush_E         (flush_E),
    .flush_W         (flush_W),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    chk(tag, 32'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}), 32'(exp));
  endtask

  task automatic idle();
    rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
    memread_E = 1'b0; pcsrc_E = 1'b0; memreq_M = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    chk_out("reset_outputs", O_RST);
    tick();
    chk("reset_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_err", 32'(mem_timeout_err), 32'd0);
    chk("reset_state", 32'(dut.r_state), 32'(RUN));
    reset = 1'b0;
    #1;
    chk_out("idle", O_NONE);

    // Load-use on rs2
    memread_E = 1'b1; rd_E = 5'd5; rs2_D = 5'd5; rs1_D = 5'd1;
    #1; chk_out("lwstall_rs2", O_LW);
    tick();
    chk("lw_cnt", 32'(stall_cycles), 32'd1);
    idle();
    #1; chk_out("after_lw", O_NONE);

    // x0 never stalls
    memread_E = 1'b1; rd_E = 5'd0; rs1_D = 5'd0;
    #1; chk_out("x0_no_stall", O_NONE);
    tick();
    chk("x0_cnt", 32'(stall_cycles), 32'd1);

    // Branch wins over load-use
    memread_E = 1'b1; rd_E = 5'd5; rs1_D = 5'd5; pcsrc_E = 1'b1;
    #1; chk_out("branch_over_lw", O_BRANCH);
    tick();
    chk("branch_cnt", 32'(stall_cycles), 32'd1);

    // Single-cycle memory access
    idle();
    memreq_M = 1'b1; dmem_ready = 1'b1;
    #1; chk_out("mem_1cyc", O_NONE);
    tick();
    chk("mem_1cyc_state", 32'(dut.r_state), 32'(RUN));

    // Three-cycle memory access: two freeze cycles
    do_reset();
    memreq_M = 1'b1; dmem_ready = 1'b0;
    #1; chk_out("mem3_c1", O_FREEZE);
    tick();
    chk("mem3_state1", 32'(dut.r_state), 32'(MEM_WAIT));
    #1; chk_out("mem3_c2", O_FREEZE);
    tick();
    chk("mem3_state2", 32'(dut.r_state), 32'(MEM_WAIT));
    dmem_ready = 1'b1;
    #1; chk_out("mem3_c3", O_NONE);
    tick();
    chk("mem3_state3", 32'(dut.r_state), 32'(RUN));
    chk("mem3_cnt", 32'(stall_cycles), 32'd2);

    // Branch held during freeze, applied in the ready cycle
    idle();
    memreq_M = 1'b1; pcsrc_E = 1'b1;
    #1; chk_out("fzbr_c1", O_FREEZE);
    tick();
    memread_E = 1'b1; rd_E = 5'd3; rs1_D = 5'd3;
    #1; chk_out("fzbr_c2", O_FREEZE);
    tick();
    dmem_ready = 1'b1;
    #1; chk_out("fzbr_ready", O_BRANCH);
    tick();
    chk("fzbr_state", 32'(dut.r_state), 32'(RUN));
    chk("fzbr_cnt", 32'(stall_cycles), 32'd4);

    // Reset in the middle of MEM_WAIT
    idle();
    memreq_M = 1'b1;
    tick();
    chk("midwait_state", 32'(dut.r_state), 32'(MEM_WAIT));
    reset = 1'b1;
    #1; chk_out("midwait_rst_out", O_RST);
    tick();
    chk("midwait_rst_state", 32'(dut.r_state), 32'(RUN));
    reset = 1'b0;
    idle();
    #1; chk_out("midwait_after", O_NONE);

    // Timeout into HALT on the fourth wait cycle
    do_reset();
    memreq_M = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_wait_state", 32'(dut.r_state), 32'(MEM_WAIT));
      chk("to_wait_err", 32'(mem_timeout_err), 32'd0);
    end
    tick();
    chk("to_halt_state", 32'(dut.r_state), 32'(HALT));
    chk("to_halt_err", 32'(mem_timeout_err), 32'd1);
    chk("to_halt_cnt", 32'(stall_cycles), 32'd4);
    memreq_M = 1'b0; dmem_ready = 1'b1; pcsrc_E = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1; chk_out("halt_freeze", O_FREEZE);
      tick();
    end
    chk("halt_state_kept", 32'(dut.r_state), 32'(HALT));
    chk("halt_err_kept", 32'(mem_timeout_err), 32'd1);
    chk("halt_cnt_sat", 32'(stall_cycles), 32'd7);
    reset = 1'b1;
    #1; chk_out("halt_rst_out", O_RST);
    tick();
    chk("halt_rst_state", 32'(dut.r_state), 32'(RUN));
    chk("halt_rst_err", 32'(mem_timeout_err), 32'd0);
    chk("halt_rst_cnt", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    idle();
    #1; chk_out("halt_after", O_NONE);

    // Counter saturation under a sustained load-use stall
    memread_E = 1'b1; rd_E = 5'd9; rs1_D = 5'd9;
    for (int i = 1; i <= 10; i++) begin
      #1; chk_out("sat_lw", O_LW);
      tick();
      chk("sat_cnt", 32'(stall_cycles), (i < 7) ? 32'(i) : 32'd7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
